// File: rtl/logic_gate_accum.sv
// -----------------------------------------------------------------------------
// logic_gate_accum
//
// Streaming N-operand, WIDTH-bit bitwise gate reducer. Operands arrive on a
// valid/ready input handshake; a frame ends with in_last. The frame is folded
// with the gate chosen by op on its first beat, and one result word plus the
// frame beat count is then offered on a valid/ready output handshake.
//
// Gate select (op, sampled on the first beat only):
//   000 AND   001 OR   010 XOR   011 NAND   100 NOR   101 XNOR
//   110 / 111 illegal: the frame is consumed, out_data=0 and out_err=1.
//
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept an operand (state-only)
//   in_data    in   operand, WIDTH bits
//   in_last    in   final beat of the frame
//   op         in   gate select, 3 bits
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   out_data   out  reduced result, WIDTH bits
//   out_count  out  beats in the frame, saturating, CNT_W bits
//   out_ovf    out  beat count saturated
//   out_err    out  frame used an illegal op
// -----------------------------------------------------------------------------
module logic_gate_accum #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [2:0]       op_q, op_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf, ovf_nx;

  logic             beat;
  logic             op_illegal;
  logic             op_invert;
  logic [WIDTH-1:0] result;

  // One accumulation step. The inverting gates fold with their base function;
  // the inversion is applied once at the output so that an N-operand NAND is
  // ~(a & b & c ...) rather than a chain of 2-input NANDs.
  function automatic logic [WIDTH-1:0] gate_step(
    input logic [2:0]       sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = a & b;
    case (sel)
      OP_AND,  OP_NAND: r = a & b;
      OP_OR,   OP_NOR:  r = a | b;
      OP_XOR,  OP_XNOR: r = a ^ b;
      default:          r = a & b;  // illegal op: value is discarded at output
    endcase
    return r;
  endfunction

  assign in_ready = (state != S_DONE);
  assign beat     = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_nx = state;
    acc_nx   = acc;
    op_nx    = op_q;
    cnt_nx   = cnt;
    ovf_nx   = ovf;

    case (state)
      S_IDLE: begin
        if (beat) begin
          acc_nx   = in_data;
          op_nx    = op;
          cnt_nx   = CNT_ONE;
          ovf_nx   = 1'b0;
          state_nx = in_last ? S_DONE : S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (beat) begin
          acc_nx = gate_step(op_q, acc, in_data);
          if (cnt == CNT_MAX) begin
            ovf_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
          if (in_last) begin
            state_nx = S_DONE;
          end
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_nx = S_IDLE;
        end
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the datapath registers are reset along with the state so that the
  // visible output values are defined from the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= '0;
      op_q  <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state <= state_nx;
      acc   <= acc_nx;
      op_q  <= op_nx;
      cnt   <= cnt_nx;
      ovf   <= ovf_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Result selection
  // ---------------------------------------------------------------------------
  // All outputs are decoded from registers only, so there is no combinational
  // path from in_* to out_*. Nothing changes these registers while in S_DONE,
  // which keeps the result stable under backpressure.
  assign op_illegal = (op_q[2:1] == 2'b11);
  assign op_invert  = (op_q == OP_NAND) || (op_q == OP_NOR) || (op_q == OP_XNOR);

  always_comb begin
    result = acc;
    if (op_illegal) begin
      result = '0;
    end else if (op_invert) begin
      result = ~acc;
    end
  end

  // Outputs read zero whenever no result is being offered.
  assign out_valid = (state == S_DONE);
  assign out_data  = out_valid ? result : '0;
  assign out_count = out_valid ? cnt    : '0;
  assign out_ovf   = out_valid & ovf;
  assign out_err   = out_valid & op_illegal;

endmodule

// File: tb/tb_logic_gate_accum.sv
// -----------------------------------------------------------------------------
// tb_logic_gate_accum
//
// Directed bench for logic_gate_accum. Two instances share every input:
// dut (CNT_W=8) and dut_s (CNT_W=2, for beat-count saturation). A table of
// two-beat frames covers every gate select; hand-written sequences cover
// latency, backpressure, mid-frame op change, single-beat frames, saturation
// and reset in the middle of a frame.
// -----------------------------------------------------------------------------
module tb_logic_gate_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic [2:0] op;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_ovf,  out_err;
  logic [7:0] out_data,  out_count;
  logic       in_ready_s, out_valid_s, out_ovf_s, out_err_s;
  logic [7:0] out_data_s;
  logic [1:0] out_count_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic_gate_accum #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_ovf(out_ovf), .out_err(out_err)
  );

  logic_gate_accum #(.WIDTH(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .in_last(in_last), .op(op),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_count(out_count_s), .out_ovf(out_ovf_s), .out_err(out_err_s)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called just after a rising edge. Presents one beat, waits (bounded) for
  // in_ready, lets one edge transfer it, then drops in_valid.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic [2:0] o);
    int budget;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    op       = o;
    budget   = 20;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"and",   3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{"or",    3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0};
    vecs[2] = '{"xor",   3'b010, 8'hF0, 8'h3C, 8'hCC, 1'b0};
    vecs[3] = '{"nand",  3'b011, 8'hF0, 8'h3C, 8'hCF, 1'b0};
    vecs[4] = '{"nor",   3'b100, 8'hF0, 8'h3C, 8'h03, 1'b0};
    vecs[5] = '{"xnor",  3'b101, 8'hF0, 8'h3C, 8'h33, 1'b0};
    vecs[6] = '{"ill110",3'b110, 8'hF0, 8'h3C, 8'h00, 1'b1};
    vecs[7] = '{"ill111",3'b111, 8'hA5, 8'h5A, 8'h00, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    op        = 3'b000;
    out_ready = 1'b1;

    // ---- reset values ----
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_out_err",   32'(out_err),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- OR, 3 beats: latency and single-cycle out_valid ----
    send_beat(8'h01, 1'b0, 3'b001);
    check("or3_no_early_valid", 32'(out_valid), 32'd0);
    send_beat(8'h10, 1'b0, 3'b001);
    send_beat(8'h80, 1'b1, 3'b001);
    check("or3_valid",   32'(out_valid), 32'd1);
    check("or3_ready",   32'(in_ready),  32'd0);
    check("or3_data",    32'(out_data),  32'h91);
    check("or3_count",   32'(out_count), 32'd3);
    check("or3_err",     32'(out_err),   32'd0);
    @(posedge clk); #1;
    check("or3_valid_drop", 32'(out_valid), 32'd0);
    check("or3_ready_back", 32'(in_ready),  32'd1);

    // ---- table: every gate select on a 2-beat frame ----
    for (int i = 0; i < 8; i++) begin
      send_beat(vecs[i].a, 1'b0, vecs[i].op);
      send_beat(vecs[i].b, 1'b1, vecs[i].op);
      check({vecs[i].name, "_valid"}, 32'(out_valid), 32'd1);
      check({vecs[i].name, "_data"},  32'(out_data),  32'(vecs[i].exp_data));
      check({vecs[i].name, "_count"}, 32'(out_count), 32'd2);
      check({vecs[i].name, "_err"},   32'(out_err),   32'(vecs[i].exp_err));
      @(posedge clk); #1;
    end

    // ---- mid-frame op change is ignored (XOR frame, AND on beat 2) ----
    send_beat(8'hF0, 1'b0, 3'b010);
    send_beat(8'h3C, 1'b1, 3'b000);
    check("opchg_data", 32'(out_data), 32'hCC);
    @(posedge clk); #1;

    // ---- single-beat NOR ----
    send_beat(8'h0F, 1'b1, 3'b100);
    check("nor1_data",  32'(out_data),  32'hF0);
    check("nor1_count", 32'(out_count), 32'd1);
    @(posedge clk); #1;

    // ---- backpressure: 5 cycles held, pending input not accepted ----
    out_ready = 1'b0;
    send_beat(8'h55, 1'b0, 3'b101);
    send_beat(8'h0F, 1'b1, 3'b001);   // XNOR: ~(0x55 ^ 0x0F) = 0xA5
    in_valid = 1'b1;                   // next frame waits: AND 0x5A, 1 beat
    in_data  = 8'h5A;
    in_last  = 1'b1;
    op       = 3'b000;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready),  32'd0);
      check("bp_data",  32'(out_data),  32'hA5);
      check("bp_count", 32'(out_count), 32'd2);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;               // output transfer, back in IDLE
    check("bp_after_valid", 32'(out_valid), 32'd0);
    check("bp_after_ready", 32'(in_ready),  32'd1);
    @(posedge clk); #1;               // pending beat accepted now
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_data",  32'(out_data),  32'h5A);
    check("bp_next_count", 32'(out_count), 32'd1);
    @(posedge clk); #1;

    // ---- saturation: 5-beat OR, CNT_W=8 vs CNT_W=2 ----
    send_beat(8'h01, 1'b0, 3'b001);
    send_beat(8'h02, 1'b0, 3'b001);
    send_beat(8'h04, 1'b0, 3'b001);
    send_beat(8'h08, 1'b0, 3'b001);
    send_beat(8'h10, 1'b1, 3'b001);
    check("sat8_count", 32'(out_count),   32'd5);
    check("sat8_ovf",   32'(out_ovf),     32'd0);
    check("sat2_valid", 32'(out_valid_s), 32'd1);
    check("sat2_count", 32'(out_count_s), 32'd3);
    check("sat2_ovf",   32'(out_ovf_s),   32'd1);
    check("sat2_data",  32'(out_data_s),  32'h1F);
    @(posedge clk); #1;

    // ---- reset mid-frame: 2 of 4 beats, then asynchronous reset ----
    send_beat(8'hFF, 1'b0, 3'b000);
    send_beat(8'h0F, 1'b0, 3'b000);
    #2 rst = 1'b1;
    #1;
    check("rstmid_ready", 32'(in_ready),  32'd1);
    check("rstmid_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstmid_no_result", 32'(out_valid), 32'd0);
    send_beat(8'hAA, 1'b1, 3'b000);
    check("rstmid_and_valid", 32'(out_valid), 32'd1);
    check("rstmid_and_data",  32'(out_data),  32'hAA);
    check("rstmid_and_count", 32'(out_count), 32'd1);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
